// File: rtl/div_pkg.sv
// Shared encodings for the iterative divide unit: funct3 codes, FSM states
// and helpers that classify an operation.
package div_pkg;

  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM  = 3'd6;
  localparam logic [2:0] F3_REMU = 3'd7;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Unknown codes fall through as DIVU: unsigned, quotient selected.
  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, retire a quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN:0]   w_sub;
  logic            w_fits;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_fits  = (w_shift >= {2'b00, i_div});
  assign w_sub   = w_shift[XLEN:0] - {1'b0, i_div};
  assign o_rem   = w_fits ? w_sub : w_shift[XLEN:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/div_unit_iter.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit retiring STEPS quotient bits per
// cycle; result is held on the CDB interface until granted or flushed.
module div_unit_iter
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             queue_en,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             tag_in_valid,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  res,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_out_valid,
  output logic             busy
);

  localparam int ITERS = XLEN / STEPS;
  localparam int CNT_W = $clog2(ITERS + 1);

  state_t             r_state, w_next_state;
  logic [XLEN-1:0]    r_op1, r_op2, r_quo, r_div, r_res;
  logic [XLEN:0]      r_rem;
  logic [2:0]         r_funct3;
  logic [TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]   r_count;
  logic               r_neg_q, r_neg_r;

  logic               w_accept, w_signed, w_is_rem, w_op1_neg, w_op2_neg;
  logic               w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0]    w_mag1, w_mag2, w_special_res, w_quo_fix, w_rem_fix;
  logic [XLEN:0]      w_rem_chain [STEPS+1];
  logic [XLEN-1:0]    w_quo_chain [STEPS+1];

  assign w_accept   = (r_state == IDLE) && queue_en && tag_in_valid && !flush;
  assign w_signed   = f3_is_signed(r_funct3);
  assign w_is_rem   = f3_is_rem(r_funct3);
  assign w_op1_neg  = w_signed & r_op1[XLEN-1];
  assign w_op2_neg  = w_signed & r_op2[XLEN-1];
  // Negating the most-negative value yields itself, which reads as 2^(XLEN-1) unsigned.
  assign w_mag1     = w_op1_neg ? -r_op1 : r_op1;
  assign w_mag2     = w_op2_neg ? -r_op2 : r_op2;
  assign w_div_zero = (r_op2 == '0);
  assign w_ovf      = w_signed && (r_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_op2 == '1);
  assign w_special  = w_div_zero | w_ovf;
  assign w_special_res = w_div_zero ? (w_is_rem ? r_op1 : '1)
                                    : (w_is_rem ? '0 : r_op1);
  assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  assign w_rem_chain[0] = r_rem;
  assign w_quo_chain[0] = r_quo;
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .i_rem (w_rem_chain[gi]),
      .i_quo (w_quo_chain[gi]),
      .i_div (r_div),
      .o_rem (w_rem_chain[gi+1]),
      .o_quo (w_quo_chain[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (queue_en && tag_in_valid) w_next_state = PREP;
        PREP:    w_next_state = w_special ? DONE : CALC;
        CALC:    if (r_count == CNT_W'(1)) w_next_state = FIX;
        FIX:     w_next_state = DONE;
        DONE:    if (cdb_grant) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_funct3 <= '0;
      r_tag    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_res    <= '0;
      r_count  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op1    <= op1;
          r_op2    <= op2;
          r_funct3 <= funct3;
          r_tag    <= tag_in;
        end
        PREP: begin
          r_neg_q <= w_op1_neg ^ w_op2_neg;
          r_neg_r <= w_op1_neg;
          r_quo   <= w_mag1;
          r_div   <= w_mag2;
          r_rem   <= '0;
          r_count <= CNT_W'(ITERS);
          r_res   <= w_special_res;
        end
        CALC: begin
          r_rem   <= w_rem_chain[STEPS];
          r_quo   <= w_quo_chain[STEPS];
          r_count <= r_count - CNT_W'(1);
        end
        FIX:     r_res <= w_is_rem ? w_rem_fix : w_quo_fix;
        default: ;
      endcase
    end
  end

  assign tag_out_valid = (r_state == DONE);
  assign res           = tag_out_valid ? r_res : '0;
  assign tag_out       = tag_out_valid ? r_tag : '0;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_div_unit_iter.sv
// Directed and randomized checks of div_unit_iter at STEPS=1 and STEPS=4
// against an arithmetic reference model.
module tb_div_unit_iter;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_q = 1'b0, in_tv = 1'b0, in_flush = 1'b0, in_grant = 1'b0;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic [2:0]  in_f3 = '0;
  logic [5:0]  in_tag = '0;
  bit          sel4 = 1'b0;

  logic        q1, q4;
  logic [31:0] res1, res4;
  logic [5:0]  tag1, tag4;
  logic        v1, v4, busy1, busy4;
  logic [31:0] obs_res;
  logic [5:0]  obs_tag;
  logic        obs_v, obs_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign q1       = in_q & ~sel4;
  assign q4       = in_q & sel4;
  assign obs_res  = sel4 ? res4  : res1;
  assign obs_tag  = sel4 ? tag4  : tag1;
  assign obs_v    = sel4 ? v4    : v1;
  assign obs_busy = sel4 ? busy4 : busy1;

  div_unit_iter #(.XLEN(32), .TAG_W(6), .STEPS(1)) u_dut1 (
    .clk(clk), .rst(rst), .queue_en(q1), .op1(in_op1), .op2(in_op2),
    .funct3(in_f3), .tag_in(in_tag), .tag_in_valid(in_tv), .flush(in_flush),
    .cdb_grant(in_grant), .res(res1), .tag_out(tag1), .tag_out_valid(v1),
    .busy(busy1)
  );

  div_unit_iter #(.XLEN(32), .TAG_W(6), .STEPS(4)) u_dut4 (
    .clk(clk), .rst(rst), .queue_en(q4), .op1(in_op1), .op2(in_op2),
    .funct3(in_f3), .tag_in(in_tag), .tag_in_valid(in_tv), .flush(in_flush),
    .cdb_grant(in_grant), .res(res4), .tag_out(tag4), .tag_out_valid(v4),
    .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // RISC-V division semantics via 64-bit host arithmetic (truncating toward zero).
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    bit     sgn   = (f == F3_DIV) || (f == F3_REM);
    bit     isrem = (f == F3_REM) || (f == F3_REMU);
    longint sa, sb;
    if (b == 32'd0) return isrem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return isrem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return isrem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f, input int steps);
    bit sgn = (f == F3_DIV) || (f == F3_REM);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 32 / steps + 3;
  endfunction

  // Latency counts clock edges with the accept edge as edge 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic [5:0] t, output int lat);
    @(negedge clk);
    in_op1 = a; in_op2 = b; in_f3 = f; in_tag = t; in_q = 1'b1; in_tv = 1'b1;
    @(posedge clk); #1;
    in_q = 1'b0; in_tv = 1'b0;
    lat = 1;
    while (!obs_v && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic [5:0] t,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    in_grant = 1'b1;
    issue(a, b, f, t, lat);
    $display("txn %s: op1=%h op2=%h f3=%0d res=%h tag=%h lat=%0d",
             name, a, b, f, obs_res, obs_tag, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_res"}, obs_res, exp_res);
    check({name, "_tag"}, obs_tag, t);
    @(posedge clk); #1;
    check({name, "_idle"}, obs_busy, 1'b0);
  endtask

  initial begin
    int          lat;
    bit          saw;
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [5:0]  t;

    repeat (2) @(posedge clk);
    #1;
    check("rst_res", obs_res, 32'd0);
    check("rst_tag", obs_tag, 6'd0);
    check("rst_valid", obs_v, 1'b0);
    check("rst_busy", obs_busy, 1'b0);
    @(negedge clk) rst = 1'b1;

    run_op("divu_100_7", 32'd100, 32'd7, F3_DIVU, 6'h2A, 32'd14, 35);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, F3_DIV, 6'h01, 32'hFFFF_FFFD, 35);
    run_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, F3_REM, 6'h02, 32'hFFFF_FFFF, 35);
    run_op("remu_m7_2", 32'hFFFF_FFF9, 32'd2, F3_REMU, 6'h03, 32'd1, 35);
    run_op("div_5_0", 32'd5, 32'd0, F3_DIV, 6'h04, 32'hFFFF_FFFF, 2);
    run_op("rem_5_0", 32'd5, 32'd0, F3_REM, 6'h05, 32'd5, 2);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, F3_DIV, 6'h06, 32'h8000_0000, 2);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, F3_REM, 6'h07, 32'd0, 2);
    run_op("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, F3_DIV, 6'h08, 32'd14, 35);
    run_op("rem_100_m7", 32'd100, 32'hFFFF_FFF9, F3_REM, 6'h09, 32'd2, 35);
    run_op("f3_0_as_divu", 32'hFFFF_FFF9, 32'd2, 3'd0, 6'h0A, 32'h7FFF_FFFC, 35);

    // Backpressure: result held, issues ignored.
    in_grant = 1'b0;
    issue(32'd1000, 32'd10, F3_DIVU, 6'h11, lat);
    check("bp_lat", lat, 35);
    check("bp_res0", obs_res, 32'd100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_q = 1'b1; in_tv = 1'b1; in_op1 = $urandom; in_op2 = 32'd3; in_tag = 6'(i);
      @(posedge clk); #1;
      $display("txn bp_hold %0d: res=%h tag=%h valid=%b busy=%b", i, obs_res, obs_tag, obs_v, obs_busy);
      check("bp_res", obs_res, 32'd100);
      check("bp_tag", obs_tag, 6'h11);
      check("bp_valid", obs_v, 1'b1);
      check("bp_busy", obs_busy, 1'b1);
    end
    @(negedge clk);
    in_q = 1'b0; in_tv = 1'b0; in_grant = 1'b1;
    @(posedge clk); #1;
    check("bp_release_busy", obs_busy, 1'b0);
    check("bp_release_valid", obs_v, 1'b0);
    run_op("after_bp", 32'd81, 32'd9, F3_DIVU, 6'h22, 32'd9, 35);

    // Flush at the tenth edge after accept.
    @(negedge clk);
    in_op1 = 32'd500; in_op2 = 32'd3; in_f3 = F3_DIVU; in_tag = 6'h15; in_q = 1'b1; in_tv = 1'b1;
    @(posedge clk); #1;
    in_q = 1'b0; in_tv = 1'b0;
    repeat (9) @(posedge clk);
    #1 in_flush = 1'b1;
    @(posedge clk); #1;
    in_flush = 1'b0;
    check("flush_busy", obs_busy, 1'b0);
    check("flush_valid", obs_v, 1'b0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (obs_v) saw = 1'b1;
    end
    $display("txn flush: tag 15 valid_seen=%b", saw);
    check("flush_no_result", saw, 1'b0);

    // Asynchronous reset in CALC.
    @(negedge clk);
    in_op1 = 32'd77; in_op2 = 32'd5; in_f3 = F3_DIVU; in_tag = 6'h33; in_q = 1'b1; in_tv = 1'b1;
    @(posedge clk); #1;
    in_q = 1'b0; in_tv = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("calc_busy_pre", obs_busy, 1'b1);
    rst = 1'b0;
    #1;
    $display("txn rst_calc: res=%h tag=%h valid=%b busy=%b", obs_res, obs_tag, obs_v, obs_busy);
    check("rstc_busy", obs_busy, 1'b0);
    check("rstc_valid", obs_v, 1'b0);
    @(negedge clk) rst = 1'b1;

    // Asynchronous reset while a result is held.
    in_grant = 1'b0;
    issue(32'd100, 32'd7, F3_DIVU, 6'h3C, lat);
    check("rstd_res_pre", obs_res, 32'd14);
    #2 rst = 1'b0;
    #1;
    $display("txn rst_done: res=%h tag=%h valid=%b busy=%b", obs_res, obs_tag, obs_v, obs_busy);
    check("rstd_res", obs_res, 32'd0);
    check("rstd_tag", obs_tag, 6'd0);
    check("rstd_valid", obs_v, 1'b0);
    check("rstd_busy", obs_busy, 1'b0);
    @(negedge clk) rst = 1'b1;
    in_grant = 1'b1;

    // Randomized operations on the STEPS=4 instance.
    sel4 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        4, 5:    b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      f = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      t = 6'($urandom);
      run_op($sformatf("rnd4_%0d", i), a, b, f, t, ref_div(a, b, f), ref_lat(a, b, f, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit_iter.md
Name: div_unit_iter

Overview:
- Parametrised, iterative successor to the fixed-latency divide unit in the execution stage.
- Executes RISC-V M-extension DIV/DIVU/REM/REMU with a radix-2^k restoring datapath over XLEN-bit operands. Handles signed operands and the RISC-V divide-by-zero and overflow rules.
- Holds its result until the common data bus grants it, and can be flushed mid-operation on a mispredict.
- Sits between the divide reservation station (which drives queue_en) and the CDB arbiter.

Parameters:
- XLEN, 32, operand/result width; must be even.
- TAG_W, 6, reservation-station tag width.
- STEPS, 1, quotient bits retired per cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- queue_en  in  1  issue request from the reservation station.
- op1  in  XLEN  dividend.
- op2  in  XLEN  divisor.
- funct3  in  3  4=DIV, 5=DIVU, 6=REM, 7=REMU; other codes are treated as DIVU.
- tag_in  in  TAG_W  destination tag.
- tag_in_valid  in  1  qualifies tag_in.
- flush  in  1  kill the in-flight operation.
- cdb_grant  in  1  arbiter accepted this unit's result this cycle.
- res  out  XLEN  result; zero when tag_out_valid=0.
- tag_out  out  TAG_W  result tag; zero when tag_out_valid=0.
- tag_out_valid  out  1  result pending on the CDB.
- busy  out  1  unit cannot accept an issue.

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE, all internal registers cleared, res=0, tag_out=0, tag_out_valid=0, busy=0. An in-flight operation is lost.
- Accept: on a clk edge in IDLE with queue_en=1, tag_in_valid=1 and flush=0, register op1, op2, funct3 and tag_in. queue_en while busy=1 is ignored and nothing is captured.
- busy = (state != IDLE), registered-state decode. An accept and a completion never occur in the same cycle.
- States and transitions:
  - IDLE -> PREP on accept.
  - PREP: compute signed/unsigned mode and operand magnitudes; latch quotient sign = sign(op1) XOR sign(op2) and remainder sign = sign(op1) (signed ops only); detect special cases.
    - Special case -> DONE.
    - Otherwise -> CALC with count = XLEN/STEPS.
  - CALC: each cycle performs STEPS restoring shift/subtract steps on {rem, quo}; count decrements; when count reaches 1, -> FIX.
  - FIX: apply two's-complement negation to quotient/remainder per the latched signs; select quotient (funct3 4/5) or remainder (6/7) into the result register -> DONE.
  - DONE: tag_out_valid=1; res and tag_out driven from registers, stable until granted. On cdb_grant=1 -> IDLE; otherwise stay.
- Latency, accept edge to first cycle with tag_out_valid=1:
  - Normal: XLEN/STEPS + 3 cycles (35 at defaults; 11 for XLEN=32, STEPS=4).
  - Special cases: 2 cycles.
- Special cases, RISC-V semantics:
  - op2=0: quotient = all ones (DIV and DIVU); remainder = op1 (REM and REMU).
  - Signed overflow (DIV/REM with op1 = most-negative value and op2 = all ones): quotient = op1, remainder = 0.
- Arithmetic: magnitudes are XLEN-bit unsigned, with the most-negative value handled as 2^(XLEN-1). The partial remainder is XLEN+1 bits. No truncation beyond XLEN on output.
- flush: synchronous, highest priority over accept and grant. In any state, the next state is IDLE and tag_out_valid drops at the next edge. A flush arriving in the same cycle as cdb_grant in DONE still counts as granted for the arbiter; the unit simply returns to IDLE.
- Held result: while tag_out_valid=1 and cdb_grant=0, res/tag_out/tag_out_valid do not change for any number of cycles.

Decomposition:
- Package div_pkg holds:
  - funct3 localparams F3_DIV=4, F3_DIVU=5, F3_REM=6, F3_REMU=7;
  - state enum {IDLE, PREP, CALC, FIX, DONE}.
- Sub-module div_step: a purely combinational single restoring step, parametrised by XLEN (partial remainder, quotient, divisor in; updated remainder and quotient out). It is instantiated STEPS times in a chain inside CALC.

Test Plan:
- DIVU 100/7, STEPS=1, grant held high -> tag_out_valid at accept+35, res=14, tag_out echoes tag_in (e.g. 6'h2A), then busy=0 on the next cycle.
- DIV -7/2 and REM -7/2 (0xFFFFFFF9, 2) -> res=0xFFFFFFFD (-3) and 0xFFFFFFFF (-1); REMU 0xFFFFFFF9/2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF at accept+2; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure: hold cdb_grant=0 for 10 cycles in DONE -> outputs constant and busy=1; queue_en pulses during the hold are ignored; grant -> IDLE, and a new issue is accepted next.
- flush at accept+10 -> no tag_out_valid ever for that tag, busy=0 next cycle. Async rst=0 mid-CALC -> all outputs 0 immediately.
- STEPS=4 build: random signed/unsigned operands vs reference model, latency exactly 11.
